sdram_req_arbiter: RTL and testbench
====================================

SDRAM_REQ_ARBITER -- requirements
Module: sdram_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles one transaction may spend in ISSUE plus WAIT_DONE before it is aborted.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_valid  input  1  instruction-port read request; held until accepted.
REQ-005 i_addr  input  26  instruction-port byte address.
REQ-006 i_ready  output  1  instruction request accepted this cycle.
REQ-007 i_done  output  1  one-cycle pulse on instruction transaction completion.
REQ-008 i_rdata  output  32  instruction read data; valid when i_done=1.
REQ-009 d_valid  input  1  data-port request; held until accepted.
REQ-010 d_addr  input  26  data-port byte address.
REQ-011 d_wdata  input  32  data-port write data.
REQ-012 d_wlen  input  2  data-port operation: 00 read32, 01 write8, 10 write16, 11 write32.
REQ-013 d_ready  output  1  data request accepted this cycle.
REQ-014 d_done  output  1  one-cycle pulse on data transaction completion.
REQ-015 d_rdata  output  32  data read data; valid when d_done=1 and the accepted op was 00.
REQ-016 err  output  1  one-cycle pulse, coincident with i_done or d_done, on a timed-out transaction.
REQ-017 mem_address  output  26  address to SDRAM controller.
REQ-018 mem_wdata  output  32  write data to SDRAM controller.
REQ-019 mem_wlen  output  2  operation code to SDRAM controller, same encoding as d_wlen.
REQ-020 mem_en_n  output  1  active-low request strobe to SDRAM controller.
REQ-021 mem_ready  input  1  controller status: low while busy, high when idle/done.
REQ-022 mem_rdata  input  32  controller read data.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT_DONE.
REQ-024 IDLE: i_ready and d_ready are combinational and asserted only in IDLE, only for the arbitration winner, and only when that port's valid=1.
REQ-025 On acceptance, the winner's addr, wdata, and wlen are latched into mem_address, mem_wdata, and mem_wlen (the instruction port forces wlen=00, wdata=0), the owner is recorded, and the FSM goes to ISSUE.
REQ-026 ISSUE: mem_en_n=0; on the first posedge sampling mem_ready=0, the FSM goes to WAIT_DONE and mem_en_n returns to 1 in that same transition.
REQ-027 WAIT_DONE: mem_en_n=1; on the first posedge sampling mem_ready=1, the owner's done pulses next cycle, and for reads the owner's rdata captures mem_rdata at that edge. The FSM then returns to IDLE.
REQ-028 Minimum latency: accept edge to done pulse is 3 cycles with an immediately responding controller; a new request can be accepted in the cycle after done.
REQ-029 mem_address, mem_wdata, and mem_wlen shall remain stable from acceptance until return to IDLE.
REQ-030 Timeout: a counter clears on acceptance and increments each cycle in ISSUE or WAIT_DONE. When it reaches TIMEOUT_CYCLES-1, the FSM forces IDLE, sets mem_en_n=1, pulses owner done plus err, and drives owner rdata to 0.
REQ-031 i_rdata and d_rdata shall hold their last value between completions.
REQ-032 Valid deasserted before acceptance shall be ignored; no transaction is issued.
REQ-033 Only one outstanding transaction at a time; no request is accepted outside IDLE.

Reset
REQ-034 On rst=1 at posedge: state IDLE, mem_en_n=1, mem_address/mem_wdata/mem_wlen=0, i_done/d_done/err=0, i_rdata/d_rdata=0, timeout counter 0, last-grant=instruction.
REQ-035 Reset mid-transaction abandons it: no done or err pulse, and mem_en_n=1 from the reset edge.

Configuration
REQ-036 Macro SDRAM_ARB_ROUND_ROBIN_EN defined: when both ports are valid in IDLE, the port not granted last wins. Last-grant updates on every acceptance.
REQ-037 Macro undefined: fixed priority, data port always wins ties, and last-grant is unused.
REQ-038 A single valid port always wins regardless of configuration.

Verification
REQ-039 Data read 0x0000100, controller drops mem_ready 1 cycle after mem_en_n=0 and raises it 4 cycles later with mem_rdata=0xDEADBEEF -> single d_done pulse, d_rdata=0xDEADBEEF, err=0.
REQ-040 Data write8 addr 0x0000003, wdata 0x000000A5 -> mem_wlen=01, mem_address=0x0000003, mem_wdata=0x000000A5 stable until d_done, and i_done never pulses.
REQ-041 i_valid and d_valid held high for 4 transactions with ROUND_ROBIN_EN defined -> grant order D,I,D,I. With the macro undefined -> D,D,D,D.
REQ-042 Controller keeps mem_ready=1 permanently, TIMEOUT_CYCLES=64 -> exactly 64 cycles after acceptance, owner done and err pulse, owner rdata=0, FSM back in IDLE.
REQ-043 rst asserted for one cycle while in WAIT_DONE -> mem_en_n=1, no done or err pulse, next request accepted normally.

Source files
------------

// File: rtl/sdram_req_arbiter_if.sv
// Bundle of the instruction port, data port and SDRAM controller signals of sdram_req_arbiter.
// The arbiter connects through the slave modport; the client/controller side uses master.
interface sdram_req_arbiter_if;
    logic        i_valid;
    logic [25:0] i_addr;
    logic        i_ready;
    logic        i_done;
    logic [31:0] i_rdata;

    logic        d_valid;
    logic [25:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_wlen;
    logic        d_ready;
    logic        d_done;
    logic [31:0] d_rdata;

    logic        err;

    logic [25:0] mem_address;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_wlen;
    logic        mem_en_n;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wlen, mem_ready, mem_rdata,
        output i_ready, i_done, i_rdata, d_ready, d_done, d_rdata, err,
               mem_address, mem_wdata, mem_wlen, mem_en_n
    );

    modport master (
        output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wlen, mem_ready, mem_rdata,
        input  i_ready, i_done, i_rdata, d_ready, d_done, d_rdata, err,
               mem_address, mem_wdata, mem_wlen, mem_en_n
    );
endinterface

// File: rtl/sdram_req_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-transaction SDRAM controller, with timeout.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the data port has fixed priority.
module sdram_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_req_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             owner_d;
    logic             grant_d;
    logic             accept;
    logic             timeout;
    logic             complete;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic             last_grant_d;

    always_comb begin
        grant_d = bus.d_valid;
        if (bus.d_valid && bus.i_valid) begin
            grant_d = !last_grant_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b0;
        end else if (accept) begin
            last_grant_d <= grant_d;
        end
    end
`else
    always_comb begin
        grant_d = bus.d_valid;
    end
`endif

    assign accept       = (state == IDLE) && (bus.i_valid || bus.d_valid);
    assign bus.i_ready  = (state == IDLE) && bus.i_valid && !grant_d;
    assign bus.d_ready  = (state == IDLE) && bus.d_valid && grant_d;
    assign timeout      = (state != IDLE) && (cnt == CNT_LAST);
    assign bus.mem_en_n = (state != ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timeout takes precedence over a completion seen on the same edge.
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (!bus.mem_ready) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (bus.mem_ready) begin
                    state_next = IDLE;
                    complete   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            owner_d         <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_wlen    <= '0;
            bus.i_done      <= 1'b0;
            bus.d_done      <= 1'b0;
            bus.err         <= 1'b0;
            bus.i_rdata     <= '0;
            bus.d_rdata     <= '0;
        end else begin
            bus.i_done <= 1'b0;
            bus.d_done <= 1'b0;
            bus.err    <= 1'b0;
            if (accept) begin
                cnt             <= '0;
                owner_d         <= grant_d;
                bus.mem_address <= grant_d ? bus.d_addr  : bus.i_addr;
                bus.mem_wdata   <= grant_d ? bus.d_wdata : 32'h0;
                bus.mem_wlen    <= grant_d ? bus.d_wlen  : 2'b00;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
                if (timeout) begin
                    bus.err <= 1'b1;
                    if (owner_d) begin
                        bus.d_done  <= 1'b1;
                        bus.d_rdata <= '0;
                    end else begin
                        bus.i_done  <= 1'b1;
                        bus.i_rdata <= '0;
                    end
                end else if (complete) begin
                    // Data-port writes leave d_rdata untouched.
                    if (owner_d) begin
                        bus.d_done <= 1'b1;
                        if (bus.mem_wlen == 2'b00) begin
                            bus.d_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        bus.i_done  <= 1'b1;
                        bus.i_rdata <= bus.mem_rdata;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Self-checking bench for sdram_req_arbiter: scripted controller timing, randomized traffic,
// and a transaction-level model predicting grants, done/err timing and returned data.
module tb_sdram_req_arbiter;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;

    sdram_req_arbiter_if bus ();

    sdram_req_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if (bus.mem_en_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_en_n: got %b expected 1", bus.mem_en_n);
        end
        checks++;
        if ({bus.mem_address, bus.mem_wdata, bus.mem_wlen} !== 60'h0) begin
            errors++;
            $display("[TB] FAIL reset_mem_bus: got %h expected 0",
                     {bus.mem_address, bus.mem_wdata, bus.mem_wlen});
        end
        checks++;
        if ({bus.i_done, bus.d_done, bus.err} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_pulses: got %b expected 000", {bus.i_done, bus.d_done, bus.err});
        end
        checks++;
        if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", {bus.i_rdata, bus.d_rdata});
        end
        checks++;
        if ({bus.i_ready, bus.d_ready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 00", {bus.i_ready, bus.d_ready});
        end
        @(posedge clk);
        #1;
    endtask

    // One transaction from a single port. The controller drops mem_ready drop_lat cycles
    // after acceptance and keeps it low for busy cycles; drop_lat >= TIMEOUT means never.
    task automatic run_txn(input bit is_d, input logic [25:0] addr, input logic [31:0] wdata,
                           input logic [1:0] wlen, input int drop_lat, input int busy,
                           input logic [31:0] rd, input bit noise);
        int          dn;
        bit          to;
        logic [1:0]  op;
        logic [31:0] wd;
        logic [59:0] exp_bus;
        logic        exp_en_n;
        op = is_d ? wlen : 2'b00;
        wd = is_d ? wdata : 32'h0;
        dn = drop_lat + busy + 1;
        to = (dn >= TIMEOUT);
        if (to) dn = TIMEOUT;
        exp_bus = {addr, wd, op};

        if (is_d) begin
            bus.d_valid = 1'b1;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
            bus.d_wlen  = wlen;
        end else begin
            bus.i_valid = 1'b1;
            bus.i_addr  = addr;
        end
        bus.mem_rdata = rd;
        @(negedge clk);
        checks++;
        if ({bus.i_ready, bus.d_ready} !== {!is_d, is_d}) begin
            errors++;
            $display("[TB] FAIL txn_grant: got %b expected %b", {bus.i_ready, bus.d_ready}, {!is_d, is_d});
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        bus.i_addr  = 26'($urandom);
        bus.d_addr  = 26'($urandom);
        bus.d_wdata = $urandom;
        bus.d_wlen  = 2'($urandom);

        for (int k = 0; k <= dn; k++) begin
            bus.mem_ready = (k < drop_lat) || (k >= drop_lat + busy);
            if (noise) begin
                if (is_d) bus.i_valid = (k < dn - 1);
                else      bus.d_valid = (k < dn - 1);
            end
            @(negedge clk);
            if (k == dn) begin
                if (to) begin
                    if (is_d) exp_d_rdata = 32'h0;
                    else      exp_i_rdata = 32'h0;
                end else if (!is_d) begin
                    exp_i_rdata = rd;
                end else if (op == 2'b00) begin
                    exp_d_rdata = rd;
                end
            end
            exp_en_n = !((k <= drop_lat) && (k < dn));
            checks++;
            if (bus.mem_en_n !== exp_en_n) begin
                errors++;
                $display("[TB] FAIL txn_en_n phase %0d: got %b expected %b", k, bus.mem_en_n, exp_en_n);
            end
            if (k < dn) begin
                checks++;
                if ({bus.mem_address, bus.mem_wdata, bus.mem_wlen} !== exp_bus) begin
                    errors++;
                    $display("[TB] FAIL txn_mem_bus phase %0d: got %h expected %h", k,
                             {bus.mem_address, bus.mem_wdata, bus.mem_wlen}, exp_bus);
                end
            end
            checks++;
            if ({bus.i_done, bus.d_done, bus.err} !== ((k == dn) ? {!is_d, is_d, to} : 3'b000)) begin
                errors++;
                $display("[TB] FAIL txn_pulses phase %0d: got %b expected %b", k,
                         {bus.i_done, bus.d_done, bus.err}, ((k == dn) ? {!is_d, is_d, to} : 3'b000));
            end
            checks++;
            if ({bus.i_ready, bus.d_ready} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL txn_busy_ready phase %0d: got %b expected 00", k, {bus.i_ready, bus.d_ready});
            end
            checks++;
            if ({bus.i_rdata, bus.d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin
                errors++;
                $display("[TB] FAIL txn_rdata phase %0d: got %h expected %h", k,
                         {bus.i_rdata, bus.d_rdata}, {exp_i_rdata, exp_d_rdata});
            end
            if (k < dn) begin
                @(posedge clk);
                #1;
            end
        end
        bus.mem_ready = 1'b1;
        bus.i_valid   = 1'b0;
        bus.d_valid   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({bus.i_done, bus.d_done, bus.err, bus.mem_en_n} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL txn_after: got %b expected 0001", {bus.i_done, bus.d_done, bus.err, bus.mem_en_n});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_data_read();
        run_txn(1'b1, 26'h0000100, 32'h0, 2'b00, 1, 4, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_write8();
        run_txn(1'b1, 26'h0000003, 32'h000000A5, 2'b01, 0, 3, 32'h12345678, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            run_txn(1'($urandom), 26'($urandom), $urandom, 2'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(1, 6)), $urandom, 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 26'h0000040, 32'h0, 2'b00, 1000, 1, 32'hCAFEF00D, 1'b0);
        run_txn(1'b0, 26'h0000080, 32'h0, 2'b00, 3, 1, 32'h0BADF00D, 1'b0);
        run_txn(1'b0, 26'h0000084, 32'h0, 2'b00, 2, 100, 32'h55AA55AA, 1'b0);
    endtask

    task automatic test_arbitration();
        bit          last_d;
        bit          exp_d;
        logic [31:0] rd;
        test_reset();
        last_d = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_addr  = 26'h0001000;
        bus.d_valid = 1'b1;
        bus.d_addr  = 26'h0002000;
        bus.d_wdata = 32'h11112222;
        bus.d_wlen  = 2'b11;
        @(negedge clk);
        for (int t = 0; t < 4; t++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            exp_d = !last_d;
`else
            exp_d = 1'b1;
`endif
            last_d = exp_d;
            rd = $urandom;
            bus.mem_rdata = rd;
            checks++;
            if ({bus.i_ready, bus.d_ready} !== {!exp_d, exp_d}) begin
                errors++;
                $display("[TB] FAIL arb_grant %0d: got %b expected %b", t, {bus.i_ready, bus.d_ready}, {!exp_d, exp_d});
            end
            @(posedge clk);
            #1 bus.mem_ready = 1'b1;
            @(posedge clk);
            #1 bus.mem_ready = 1'b0;
            @(posedge clk);
            #1 bus.mem_ready = 1'b1;
            repeat (2) @(negedge clk);
            if (!exp_d) exp_i_rdata = rd;
            checks++;
            if ({bus.i_done, bus.d_done, bus.err} !== {!exp_d, exp_d, 1'b0}) begin
                errors++;
                $display("[TB] FAIL arb_done %0d: got %b expected %b", t,
                         {bus.i_done, bus.d_done, bus.err}, {!exp_d, exp_d, 1'b0});
            end
            checks++;
            if ({bus.i_rdata, bus.d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin
                errors++;
                $display("[TB] FAIL arb_rdata %0d: got %h expected %h", t,
                         {bus.i_rdata, bus.d_rdata}, {exp_i_rdata, exp_d_rdata});
            end
        end
        bus.i_valid = 1'b0;
        bus.d_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({bus.i_done, bus.d_done, bus.mem_en_n} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL arb_idle: got %b expected 001", {bus.i_done, bus.d_done, bus.mem_en_n});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bus.d_valid   = 1'b1;
        bus.d_addr    = 26'h0001234;
        bus.d_wlen    = 2'b00;
        bus.mem_rdata = 32'h77778888;
        @(posedge clk);
        #1 bus.d_valid = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1 bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.mem_en_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_wait_en_n: got %b expected 1", bus.mem_en_n);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.mem_ready = 1'b1;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.i_done, bus.d_done, bus.err, bus.mem_en_n} !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL rstmid_quiet %0d: got %b expected 0001", c,
                         {bus.i_done, bus.d_done, bus.err, bus.mem_en_n});
            end
            @(posedge clk);
            #1;
        end
        run_txn(1'b0, 26'h0002000, 32'h0, 2'b00, 0, 2, 32'h13579BDF, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.i_valid   = 1'b0;
        bus.i_addr    = '0;
        bus.d_valid   = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_wlen    = '0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = '0;
        exp_i_rdata   = '0;
        exp_d_rdata   = '0;

        $display("[TB] starting");
        test_reset();
        test_data_read();
        test_write8();
        test_random();
        test_timeout();
        test_arbitration();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
